// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed 7-segment scan controller with double-buffered BCD input.
// Ports: clock, resetN (async low), enable, loadValid/loadReady/bcdIn
//   (word handshake), segmentOut (a..g = bit6..0), digitSelect (one-hot),
//   frameDone (pulse on the last cycle of each frame).
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seven_segment_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  enable,
  input  logic                  loadValid,
  output logic                  loadReady,
  input  logic [4*DIGITS-1:0]   bcdIn,
  output logic [6:0]            segmentOut,
  output logic [DIGITS-1:0]     digitSelect,
  output logic                  frameDone
);

  localparam int SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(PRESCALE - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BLANK,
    ST_DRIVE
  } state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [DW-1:0]       digit_q, digit_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic [4*DIGITS-1:0] act_q, act_d;
  logic                pendv_q, pendv_d;
  logic                actv_q, actv_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                frame_q, frame_d;
  logic                ready_q, ready_d;

  logic                boundary;
  logic                xfer;
  logic                accept;
  logic [3:0]          nib;

  function automatic state_e slot_state(input logic [SW-1:0] s);
    return (s >= BLANK_END) ? ST_DRIVE : ST_BLANK;
  endfunction

  function automatic logic [3:0] nibble_of(
    input logic [4*DIGITS-1:0] w,
    input logic [DW-1:0]       d
  );
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (d == DW'(k)) n = w[4*k +: 4];
    end
    return n;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'd0:    s = 7'h7E;
      4'd1:    s = 7'h30;
      4'd2:    s = 7'h6D;
      4'd3:    s = 7'h79;
      4'd4:    s = 7'h33;
      4'd5:    s = 7'h5B;
      4'd6:    s = 7'h5F;
      4'd7:    s = 7'h70;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h7B;
      default: s = 7'h01;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // True when digit d is above every nonzero digit; digit 0 never blanks.
  function automatic logic lead_zero(
    input logic [4*DIGITS-1:0] w,
    input logic [DW-1:0]       d
  );
    logic nz;
    nz = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (DW'(k) >= d && w[4*k +: 4] != 4'd0) nz = 1'b1;
    end
    return (d != '0) && !nz;
  endfunction
`endif

  assign accept   = loadValid && ready_q;
  assign boundary = (state_q == ST_DRIVE) && (slot_q == SLOT_LAST) &&
                    (digit_q == DIG_LAST);
  // Swap only between frames so a frame never mixes two words.
  assign xfer     = pendv_q && (boundary || state_q == ST_OFF);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    digit_d = digit_q;
    pend_d  = pend_q;
    pendv_d = pendv_q;
    act_d   = act_q;
    actv_d  = actv_q;

    if (xfer) begin
      act_d   = pend_q;
      actv_d  = 1'b1;
      pendv_d = 1'b0;
    end
    if (accept) begin
      pend_d  = bcdIn;
      pendv_d = 1'b1;
    end

    if (!enable) begin
      state_d = ST_OFF;
      slot_d  = '0;
      digit_d = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (actv_q || pendv_q) begin
            state_d = slot_state('0);
            slot_d  = '0;
            digit_d = '0;
          end
        end
        ST_BLANK, ST_DRIVE: begin
          if (slot_q == SLOT_LAST) begin
            slot_d  = '0;
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
            state_d = slot_state('0);
          end else begin
            slot_d  = slot_q + 1'b1;
            state_d = slot_state(slot_d);
          end
        end
        default: begin
          state_d = ST_OFF;
          slot_d  = '0;
          digit_d = '0;
        end
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up
  // with the state they describe.
  always_comb begin
    seg_d   = '0;
    sel_d   = '0;
    frame_d = 1'b0;
    ready_d = !pendv_d;
    nib     = nibble_of(act_d, digit_d);
    if (state_d == ST_DRIVE) begin
      seg_d = seg_of(nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (lead_zero(act_d, digit_d)) seg_d = '0;
`endif
      sel_d   = DIGITS'(1) << digit_d;
      frame_d = (slot_d == SLOT_LAST) && (digit_d == DIG_LAST);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_OFF;
      slot_q  <= '0;
      digit_q <= '0;
      pend_q  <= '0;
      pendv_q <= 1'b0;
      act_q   <= '0;
      actv_q  <= 1'b0;
      seg_q   <= '0;
      sel_q   <= '0;
      frame_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      digit_q <= digit_d;
      pend_q  <= pend_d;
      pendv_q <= pendv_d;
      act_q   <= act_d;
      actv_q  <= actv_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
      ready_q <= ready_d;
    end
  end

  assign loadReady   = ready_q;
  assign segmentOut  = seg_q;
  assign digitSelect = sel_q;
  assign frameDone   = frame_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller (DIGITS=4, PRESCALE=8, BLANK=2).
// Frame-position reference model with randomized and directed stimulus.
module tb_seven_segment_scan_controller;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = DIGITS * PRESCALE;

  logic        clock = 1'b0;
  logic        resetN;
  logic        enable;
  logic        loadValid;
  logic        loadReady;
  logic [15:0] bcdIn;
  logic [6:0]  segmentOut;
  logic [3:0]  digitSelect;
  logic        frameDone;

  logic [12:0] dut_vec;
  assign dut_vec = {segmentOut, digitSelect, frameDone, loadReady};

  seven_segment_scan_controller #(
    .DIGITS(DIGITS),
    .PRESCALE(PRESCALE),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .enable(enable),
    .loadValid(loadValid),
    .loadReady(loadReady),
    .bcdIn(bcdIn),
    .segmentOut(segmentOut),
    .digitSelect(digitSelect),
    .frameDone(frameDone)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [6:0] SEGTAB [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01
  };

  logic [15:0] m_pw, m_aw;
  logic        m_pv, m_av, m_run;
  int          m_t;
  logic        acc;

  task automatic model_reset();
    m_pw = '0; m_aw = '0;
    m_pv = 0; m_av = 0; m_run = 0;
    m_t = 0;
  endtask

  function automatic logic [12:0] model_out();
    int d, p;
    logic [3:0] nib;
    logic [6:0] s;
    logic [3:0] sel;
    if (!m_run) return {12'b0, ~m_pv};
    d = m_t / PRESCALE;
    p = m_t % PRESCALE;
    if (p < BLANK) return {12'b0, ~m_pv};
    nib = 4'(m_aw >> (4 * d));
    s   = SEGTAB[nib];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (m_aw >> (4 * d)) == 16'd0) s = 7'h00;
`endif
    sel = 4'(1 << d);
    return {s, sel, m_t == FRAME - 1, ~m_pv};
  endfunction

  task automatic tick();
    logic rdy, bnd, xf;
    @(posedge clock);
    acc = 0;
    if (!resetN) begin
      model_reset();
    end else begin
      rdy = !m_pv;
      bnd = m_run && (m_t == FRAME - 1);
      xf  = m_pv && (bnd || !m_run);
      if (!enable) begin
        m_run = 0; m_t = 0;
      end else if (!m_run) begin
        if (m_av || m_pv) begin m_run = 1; m_t = 0; end
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
      if (xf) begin m_aw = m_pw; m_av = 1; m_pv = 0; end
      if (loadValid && rdy) begin
        m_pw = bcdIn; m_pv = 1; acc = 1;
      end
    end
    @(negedge clock);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int k = 0; k < 4; k++)
      w[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0
                    : 4'($urandom_range(0, 15));
    return w;
  endfunction

  task automatic test_reset();
    resetN = 0; enable = 1; loadValid = 0; bcdIn = '0;
    model_reset();
    repeat (3) tick();
    checks++;
    if (dut_vec !== 13'h001)
      $display("FAIL reset got=%h want=%h", dut_vec, 13'h001);
    if (dut_vec !== 13'h001) errors++;
    resetN = 1;
    repeat (50) begin
      tick();
      checks++;
      if (dut_vec !== model_out()) begin
        errors++;
        $display("FAIL idle t=%0t got=%h want=%h",
                 $time, dut_vec, model_out());
      end
    end
  endtask

  task automatic test_load_1234();
    loadValid = 1; bcdIn = 16'h1234;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (acc) loadValid = 0;
      checks++;
      if (dut_vec !== model_out()) begin
        errors++;
        $display("FAIL load_1234 t=%0t got=%h want=%h",
                 $time, dut_vec, model_out());
      end
      if (i == 4 || i == 20) begin
        checks++;
        if ({segmentOut, digitSelect} !==
            ((i == 4) ? {7'h33, 4'b0001} : {7'h6D, 4'b0100})) begin
          errors++;
          $display("FAIL load_1234_digit i=%0d got=%h/%b", i,
                   segmentOut, digitSelect);
        end
      end
      if (i == 33 || i == 65) begin
        checks++;
        if (frameDone !== 1'b1) begin
          errors++;
          $display("FAIL frame_done i=%0d got=%b want=1", i, frameDone);
        end
      end
    end
  endtask

  task automatic test_midframe_load();
    for (int i = 0; i < 64 && m_t != 10; i++) tick();
    loadValid = 1; bcdIn = 16'h5678;
    repeat (80) begin
      tick();
      if (acc) loadValid = 0;
      checks++;
      if (dut_vec !== model_out()) begin
        errors++;
        $display("FAIL midframe t=%0t got=%h want=%h",
                 $time, dut_vec, model_out());
      end
    end
  endtask

  task automatic test_enable_toggle();
    for (int i = 0; i < 64 && m_t != 21; i++) tick();
    enable = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if ({segmentOut, digitSelect} !== 11'd0 ||
          dut_vec !== model_out()) begin
        errors++;
        $display("FAIL enable_off t=%0t got=%h want=%h",
                 $time, dut_vec, model_out());
      end
    end
    enable = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_out()) begin
        errors++;
        $display("FAIL enable_on t=%0t got=%h want=%h",
                 $time, dut_vec, model_out());
      end
      if (i == 1 || i == 3) begin
        checks++;
        if ({segmentOut, digitSelect} !==
            ((i == 1) ? 11'd0 : {7'h7F, 4'b0001})) begin
          errors++;
          $display("FAIL restart i=%0d got=%h/%b", i,
                   segmentOut, digitSelect);
        end
      end
    end
  endtask

  task automatic test_dash();
    loadValid = 1; bcdIn = 16'h00A7;
    repeat (75) begin
      tick();
      if (acc) loadValid = 0;
      checks++;
      if (dut_vec !== model_out()) begin
        errors++;
        $display("FAIL dash_00A7 t=%0t got=%h want=%h",
                 $time, dut_vec, model_out());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 64 && !(m_run && (m_t % PRESCALE) >= BLANK); i++)
      tick();
    #2 resetN = 0;
    #1;
    checks++;
    if (dut_vec !== 13'h001) begin
      errors++;
      $display("FAIL reset_mid got=%h want=%h", dut_vec, 13'h001);
    end
    tick();
    resetN = 1;
    repeat (30) begin
      tick();
      checks++;
      if (dut_vec !== model_out()) begin
        errors++;
        $display("FAIL after_reset t=%0t got=%h want=%h",
                 $time, dut_vec, model_out());
      end
    end
  endtask

  task automatic test_random();
    repeat (800) begin
      if (!loadValid && $urandom_range(0, 5) == 0) begin
        loadValid = 1;
        bcdIn = rand_word();
      end
      enable = ($urandom_range(0, 59) != 0);
      tick();
      if (acc) loadValid = 0;
      checks++;
      if (dut_vec !== model_out()) begin
        errors++;
        $display("FAIL random t=%0t got=%h want=%h",
                 $time, dut_vec, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_midframe_load();
    test_enable_toggle();
    test_dash();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
